// File: rtl/sqi_sram_master.sv
`default_nettype none
// ============================================================================
// Module   : sqi_sram_master
// Purpose  : Quad-SPI (SQI) initiator for a 23LC1024-class serial SRAM.
//            Issues one 16-bit READ (0x03) or WRITE (0x02) transaction at a
//            time: 2 command nibbles, 6 address nibbles, 2 dummy nibbles
//            (read only) and 4 data nibbles, MSB nibble first.
// Ports    : clk, reset (async, active high)
//            req/wr/addr/wdata : transaction request, captured when busy=0
//            rdata/ack/busy    : read result, completion pulse, activity flag
//            sQi_cs0/sQi_clk/sQi_sio : SRAM pins (mode 0, sio hi-Z when idle)
// Config   : define SQI_INIT_EN to send EQIO (0x38) in SPI mode after reset
//            so the SRAM enters SQI mode before the first transaction.
// Revision : 1.0  initial release
// ============================================================================
module sqi_sram_master #(
   parameter int CLK_DIV = 2,   // clk cycles per sQi_clk half-period (>=1)
   parameter int CS_HOLD = 2    // deselect cycles after a transaction (>=1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [23:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        sQi_cs0,
   output logic        sQi_clk,
   inout  wire  [3:0]  sQi_sio
);

   localparam int c_DIV_W  = $clog2(2 * CLK_DIV);
   localparam int c_HOLD_W = $clog2(CS_HOLD + 1);

   localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(2 * CLK_DIV - 1);
   localparam logic [c_DIV_W-1:0]  c_DIV_HALF  = c_DIV_W'(CLK_DIV);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(CS_HOLD - 1);

   localparam logic [7:0] c_CMD_READ  = 8'h03;
   localparam logic [7:0] c_CMD_WRITE = 8'h02;

   localparam logic [3:0] c_ST_IDLE  = 4'd0;
   localparam logic [3:0] c_ST_CMD   = 4'd1;
   localparam logic [3:0] c_ST_ADDR  = 4'd2;
   localparam logic [3:0] c_ST_DUMMY = 4'd3;
   localparam logic [3:0] c_ST_DATA  = 4'd4;
   localparam logic [3:0] c_ST_DESEL = 4'd5;
`ifdef SQI_INIT_EN
   localparam logic [7:0] c_CMD_EQIO = 8'h38;
   localparam logic [3:0] c_ST_IPRE  = 4'd6;   // reset/release cycle, cs still high
   localparam logic [3:0] c_ST_INIT  = 4'd7;   // EQIO bits on sio[0]
   localparam logic [3:0] c_ST_IHOLD = 4'd8;   // deselect after EQIO, no ack
   localparam logic [3:0] c_RST_STATE = c_ST_IPRE;
`else
   localparam logic [3:0] c_RST_STATE = c_ST_IDLE;
`endif

   logic [3:0]          r_state;
   logic [3:0]          w_state_nxt;
   logic [c_DIV_W-1:0]  r_div_cnt;
   logic [2:0]          r_slot_cnt;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic                r_wr;
   logic [47:0]         r_shift;    // outgoing command/address/data, MSB first
   logic [11:0]         r_rshift;   // first three read nibbles
   logic [15:0]         r_rdata;

   logic                w_slot_state;
   logic                w_hold_state;
   logic                w_slot_end;
   logic                w_phase_end;
   logic                w_hold_end;
   logic [2:0]          w_last_slot;
   logic                w_cs_n;
   logic                w_sclk;
   logic                w_busy;
   logic                w_ack;
   logic [3:0]          w_sio_oe;
   logic [3:0]          w_sio_out;

   // ------------------------------------------------------------------------
   // Slot / phase bookkeeping
   // ------------------------------------------------------------------------
   always_comb begin
      w_slot_state = 1'b0;
      w_hold_state = 1'b0;
      w_last_slot  = 3'd0;
      case (r_state)
         c_ST_CMD:   begin w_slot_state = 1'b1; w_last_slot = 3'd1; end
         c_ST_ADDR:  begin w_slot_state = 1'b1; w_last_slot = 3'd5; end
         c_ST_DUMMY: begin w_slot_state = 1'b1; w_last_slot = 3'd1; end
         c_ST_DATA:  begin w_slot_state = 1'b1; w_last_slot = 3'd3; end
         c_ST_DESEL: w_hold_state = 1'b1;
`ifdef SQI_INIT_EN
         c_ST_INIT:  begin w_slot_state = 1'b1; w_last_slot = 3'd7; end
         c_ST_IHOLD: w_hold_state = 1'b1;
`endif
         default:    ;
      endcase
   end

   assign w_slot_end  = w_slot_state && (r_div_cnt == c_DIV_LAST);
   assign w_phase_end = w_slot_end && (r_slot_cnt == w_last_slot);
   assign w_hold_end  = w_hold_state && (r_hold_cnt == c_HOLD_LAST);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_RST_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (req)         w_state_nxt = c_ST_CMD;
         c_ST_CMD:   if (w_phase_end) w_state_nxt = c_ST_ADDR;
         c_ST_ADDR:  if (w_phase_end) w_state_nxt = r_wr ? c_ST_DATA : c_ST_DUMMY;
         c_ST_DUMMY: if (w_phase_end) w_state_nxt = c_ST_DATA;
         c_ST_DATA:  if (w_phase_end) w_state_nxt = c_ST_DESEL;
         c_ST_DESEL: if (w_hold_end)  w_state_nxt = c_ST_IDLE;
`ifdef SQI_INIT_EN
         c_ST_IPRE:                   w_state_nxt = c_ST_INIT;
         c_ST_INIT:  if (w_phase_end) w_state_nxt = c_ST_IHOLD;
         c_ST_IHOLD: if (w_hold_end)  w_state_nxt = c_ST_IDLE;
`endif
         default:                     w_state_nxt = c_ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs (decoded from registered state, so reset is immediate)
   // ------------------------------------------------------------------------
   always_comb begin
      w_cs_n    = ~w_slot_state;
      w_sclk    = w_slot_state && (r_div_cnt >= c_DIV_HALF);
      w_busy    = (r_state != c_ST_IDLE);
      w_ack     = (r_state == c_ST_DESEL) && (r_hold_cnt == '0);
      w_sio_oe  = 4'h0;
      w_sio_out = r_shift[47:44];
      case (r_state)
         c_ST_CMD:  w_sio_oe = 4'hF;
         c_ST_ADDR: w_sio_oe = 4'hF;
         c_ST_DATA: w_sio_oe = r_wr ? 4'hF : 4'h0;
`ifdef SQI_INIT_EN
         c_ST_INIT: begin
            // SPI mode: single bit on sio[0], the other lines stay released
            w_sio_oe  = 4'h1;
            w_sio_out = {3'b000, r_shift[47]};
         end
`endif
         default:   ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: counters, shift registers, read capture
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div_cnt  <= '0;
         r_slot_cnt <= '0;
         r_hold_cnt <= '0;
         r_wr       <= 1'b0;
         r_shift    <= '0;
         r_rshift   <= '0;
         r_rdata    <= '0;
      end else begin
         if (w_slot_state && !w_slot_end) begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end else begin
            r_div_cnt <= '0;
         end

         if (w_phase_end || !w_slot_state) begin
            r_slot_cnt <= '0;
         end else if (w_slot_end) begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
         end

         if (w_hold_state && !w_hold_end) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end else begin
            r_hold_cnt <= '0;
         end

         // The whole transaction is frozen into r_shift at accept, so later
         // changes on wr/addr/wdata cannot disturb the bus stream.
         if ((r_state == c_ST_IDLE) && req) begin
            r_wr    <= wr;
            r_shift <= {(wr ? c_CMD_WRITE : c_CMD_READ), addr, wdata};
`ifdef SQI_INIT_EN
         end else if (r_state == c_ST_IPRE) begin
            r_shift <= {c_CMD_EQIO, 40'd0};
         end else if (w_slot_end && (r_state == c_ST_INIT)) begin
            r_shift <= {r_shift[46:0], 1'b0};
`endif
         end else if (w_slot_end) begin
            r_shift <= {r_shift[43:0], 4'h0};
         end

         // Sample on the last cycle of the high phase; the final nibble goes
         // straight into rdata so it is valid in the ack cycle.
         if ((r_state == c_ST_DATA) && !r_wr && w_slot_end) begin
            r_rshift <= {r_rshift[7:0], sQi_sio};
            if (w_phase_end) begin
               r_rdata <= {r_rshift, sQi_sio};
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Pins
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sio
         assign sQi_sio[gi] = w_sio_oe[gi] ? w_sio_out[gi] : 1'bz;
      end
   endgenerate

   assign sQi_cs0 = w_cs_n;
   assign sQi_clk = w_sclk;
   assign busy    = w_busy;
   assign ack     = w_ack;
   assign rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sqi_sram_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqi_sram_master
// Purpose  : Self-checking bench for sqi_sram_master. A small SRAM model logs
//            every nibble seen on a rising sQi_clk and returns a programmed
//            word during the read data phase. Released lines are pulled up,
//            so a released bus reads as 4'hF.
// Revision : 1.0  initial release
// ============================================================================
module tb_sqi_sram_master;

   localparam int CLK_DIV = 2;
   localparam int CS_HOLD = 2;
   localparam int SLOT    = 2 * CLK_DIV;
   localparam int LAT_WR  = 1 + 12 * SLOT;
   localparam int LAT_RD  = 1 + 14 * SLOT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [23:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata;
   logic        ack;
   logic        busy;
   logic        sQi_cs0;
   logic        sQi_clk;
   wire  [3:0]  sQi_sio;

   int n_tests = 0;
   int n_fail  = 0;

   sqi_sram_master #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .wr      (wr),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .ack     (ack),
      .busy    (busy),
      .sQi_cs0 (sQi_cs0),
      .sQi_clk (sQi_clk),
      .sQi_sio (sQi_sio)
   );

   always #5 clk = ~clk;

   pullup pu0 (sQi_sio[0]);
   pullup pu1 (sQi_sio[1]);
   pullup pu2 (sQi_sio[2]);
   pullup pu3 (sQi_sio[3]);

   // ---------------- SRAM model ----------------
   logic        m_en = 1'b0;
   logic [3:0]  m_nib = '0;
   logic [15:0] m_data = '0;
   logic [3:0]  m_log[$];

   assign sQi_sio = m_en ? m_nib : 4'bz;

   always @(negedge sQi_cs0) m_log.delete();
   always @(posedge sQi_cs0) m_en = 1'b0;
   always @(posedge sQi_clk) if (!sQi_cs0) m_log.push_back(sQi_sio);
   always @(negedge sQi_clk) begin
      int k;
      k = m_log.size() - 10;
      if (!sQi_cs0 && k >= 0 && k < 4 && m_log[1] == 4'h3) begin
         m_en  = 1'b1;
         m_nib = m_data[(15 - 4 * k) -: 4];
      end else begin
         m_en = 1'b0;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_stream(input string tag, input logic [55:0] exp, input int n);
      logic [55:0] got;
      got = '0;
      for (int i = 0; i < m_log.size() && i < 14; i++) got[(55 - 4 * i) -: 4] = m_log[i];
      check({tag, " nibble count"}, 64'(m_log.size()), 64'(n));
      check({tag, " nibble stream"}, 64'(got), 64'(exp));
   endtask

   task automatic wait_idle(input string tag);
      int cyc;
      cyc = 0;
      while (busy && cyc < 200) begin @(negedge clk); cyc++; end
      check({tag, " idle before start"}, 64'(busy), 64'd0);
   endtask

   typedef struct {
      logic        wr;
      logic [23:0] addr;
      logic [15:0] wdata;
      logic [15:0] mdata;   // word the SRAM model returns on a read
      logic [55:0] stream;  // expected nibbles on rising edges, left aligned
      int          n;
      logic [15:0] rdata;
      int          lat;
   } vec_t;

   vec_t vecs[5];

   // One request pulse; mid-transfer a second req with inverted inputs is
   // issued and must be ignored.
   task automatic run_txn(input vec_t v, input string tag);
      int cyc;
      int ack_cyc;
      wait_idle(tag);
      m_data = v.mdata;
      req = 1'b1; wr = v.wr; addr = v.addr; wdata = v.wdata;
      @(negedge clk);
      req = 1'b0;
      cyc = 1;
      check({tag, " cs low cycle 1"}, 64'(sQi_cs0), 64'd0);
      check({tag, " busy cycle 1"}, 64'(busy), 64'd1);
      ack_cyc = -1;
      while (cyc < 200) begin
         if (cyc == 20) begin req = 1'b1; wr = ~v.wr; addr = ~v.addr; wdata = ~v.wdata; end
         if (cyc == 21) req = 1'b0;
         if (ack) begin ack_cyc = cyc; break; end
         @(negedge clk);
         cyc++;
      end
      check({tag, " ack latency"}, 64'(ack_cyc), 64'(v.lat));
      check({tag, " rdata"}, 64'(rdata), 64'(v.rdata));
      check({tag, " cs/clk/sio at ack"}, {sQi_cs0, sQi_clk, sQi_sio}, {1'b1, 1'b0, 4'hF});
      check_stream(tag, v.stream, v.n);
      for (int k = 1; k <= CS_HOLD; k++) begin
         @(negedge clk);
         if (k == 1) check({tag, " ack single cycle"}, 64'(ack), 64'd0);
         if (k == CS_HOLD - 1) check({tag, " busy in deselect"}, 64'(busy), 64'd1);
         if (k == CS_HOLD) check({tag, " busy drops"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      int cyc;
      int cnt;
      logic [7:0] ibits;

      vecs[0] = '{1'b1, 24'h012345, 16'hBEEF, 16'h0000, 56'h02012345BEEF00, 12, 16'h0000, LAT_WR};
      vecs[1] = '{1'b0, 24'h000010, 16'h0000, 16'hA5C3, 56'h03000010FFA5C3, 14, 16'hA5C3, LAT_RD};
      vecs[2] = '{1'b1, 24'hFFFFFF, 16'h0000, 16'h0000, 56'h02FFFFFF000000, 12, 16'hA5C3, LAT_WR};
      vecs[3] = '{1'b0, 24'hABCDEF, 16'h0000, 16'h1234, 56'h03ABCDEFFF1234, 14, 16'h1234, LAT_RD};
      vecs[4] = '{1'b1, 24'h800001, 16'h5A5A, 16'h0000, 56'h028000015A5A00, 12, 16'h1234, LAT_WR};

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      check("reset cs/clk/sio", {sQi_cs0, sQi_clk, sQi_sio}, {1'b1, 1'b0, 4'hF});
      check("reset ack", 64'(ack), 64'd0);
      check("reset rdata", 64'(rdata), 64'd0);
`ifdef SQI_INIT_EN
      check("reset busy", 64'(busy), 64'd1);
      reset = 1'b0;
      cyc = 0;
      while (busy && cyc < 200) begin @(negedge clk); cyc++; end
      check("init busy release cycle", 64'(cyc), 64'(1 + 16 * CLK_DIV + CS_HOLD));
      ibits = '0;
      for (int i = 0; i < m_log.size() && i < 8; i++) ibits[7 - i] = m_log[i][0];
      check("init bit count", 64'(m_log.size()), 64'd8);
      check("init EQIO bits", 64'(ibits), 64'h38);
      check("init no ack", 64'(ack), 64'd0);
`else
      check("reset busy", 64'(busy), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("busy after release", 64'(busy), 64'd0);
`endif

      // ---------------- table-driven transactions ----------------
      for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // ---------------- back-to-back writes with req held ----------------
      wait_idle("b2b");
      req = 1'b1; wr = 1'b1; addr = 24'h000100; wdata = 16'h1111; m_data = '0;
      cyc = 0;
      while (!ack && cyc < 200) begin @(negedge clk); cyc++; end
      check("b2b first ack", 64'(ack), 64'd1);
      cnt = 0;
      while (sQi_cs0 && cnt < 50) begin cnt++; @(negedge clk); end
      check("b2b cs high cycles", 64'(cnt), 64'(CS_HOLD + 1));
      check("b2b second busy", 64'(busy), 64'd1);
      req = 1'b0;
      cyc = 0;
      while (!ack && cyc < 200) begin @(negedge clk); cyc++; end
      check("b2b second ack", 64'(ack), 64'd1);
      check("b2b rdata kept", 64'(rdata), 64'h1234);
      check_stream("b2b second", 56'h02000100111100, 12);

      // ---------------- reset during ADDR phase of a read ----------------
      wait_idle("abort");
      m_data = 16'hFFFF;
      req = 1'b1; wr = 1'b0; addr = 24'h000010;
      @(negedge clk);
      req = 1'b0;
      cyc = 1;
      while (cyc < 15) begin @(negedge clk); cyc++; end
      check("abort sclk high before reset", 64'(sQi_clk), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("abort cs/clk/sio", {sQi_cs0, sQi_clk, sQi_sio}, {1'b1, 1'b0, 4'hF});
      check("abort ack", 64'(ack), 64'd0);
      check("abort rdata", 64'(rdata), 64'd0);
`ifdef SQI_INIT_EN
      check("abort busy", 64'(busy), 64'd1);
`else
      check("abort busy", 64'(busy), 64'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      run_txn(vecs[1], "after abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
